wb_write_ctrl: RTL and testbench
================================

// Module: wb_write_ctrl
// PURPOSE
//  Write-back controller sitting directly upstream of the 32x32 register bank.
//  Accepts register-write requests from two sources: A (ALU) and M (load/memory).
//  Queues them in an in-order FIFO and retires at most one write per cycle.
//  Drives the bank's regwrite, one-hot cp and data inputs, and exports a pending-write
//  scoreboard (busy) for the hazard/stall logic.
// PARAMETERS
//  WIDTH      32  data word width (matches bank register width)
//  NREG       32  number of registers; cp and busy are NREG bits wide
//  AW         5   register address width, $clog2(NREG)
//  DEPTH      4   FIFO entries; power of 2, >=2
//  DISCARD_R0 1   1: requests to addr 0 are accepted and dropped (never written)
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous active-low reset
//  a_valid   in   1        source A request valid
//  a_ready   out  1        source A may enqueue this cycle
//  a_addr    in   AW       source A destination register
//  a_data    in   WIDTH    source A write data
//  m_valid   in   1        source M request valid
//  m_ready   out  1        source M may enqueue this cycle
//  m_addr    in   AW       source M destination register
//  m_data    in   WIDTH    source M write data
//  hold      in   1        1: no FIFO pop this cycle (bank-side freeze)
//  regwrite  out  1        registered write strobe to bank
//  cp        out  NREG     registered one-hot register select to bank
//  data      out  WIDTH    registered write data to bank
//  busy      out  NREG     bit i=1: a write to reg i is queued or being presented
//  count     out  $clog2(DEPTH+1)  FIFO occupancy
//  empty     out  1        count==0
//  full      out  1        count==DEPTH
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, pointers 0; regwrite=0, cp=0, data=0, busy=0,
//    count=0, empty=1, full=0. Reset mid-operation discards all queued writes.
//  - free = DEPTH - count, using occupancy before this cycle's pop.
//    No pop-to-ready bypass, so ready never depends on hold.
//  - a_ready = (free>=1). m_ready = (free >= 1 + a_valid). Ready is independent of the
//    source's own valid and of addr.
//  - Handshake: a transfer occurs on a clock edge where valid&ready.
//    valid/addr/data must stay stable until that edge.
//  - Both transfer in the same edge: A enqueued first, then M (A is older in order).
//  - DISCARD_R0=1 and addr==0: handshake completes, nothing is enqueued.
//    count and busy are unchanged.
//  - Pop: at an edge with count>0 and hold=0, the head is removed and the registers load:
//    regwrite<=1, cp<=1<<head_addr, data<=head_data.
//    Otherwise regwrite<=0 and cp<=0, and data holds its value.
//  - Latency: request accepted at edge N into an empty FIFO -> regwrite=1 during cycle
//    N+1..N+2 -> bank captures at edge N+2. Sustained throughput: 1 write/cycle.
//  - Push and pop in the same edge are allowed at any occupancy; count changes by pushes-pops.
//  - Pointers wrap modulo DEPTH. count never exceeds DEPTH or drops below 0.
//  - Retirement is strictly in FIFO order.
//  - Same address queued twice: both writes retire in order; the last one wins.
//  - busy[i] = OR over valid FIFO entries with addr==i, OR (regwrite & cp[i]).
//    Purely combinational from state.
//  - hold=1 freezes the FIFO head. Output regs go idle (regwrite=0) the next cycle;
//    enqueues continue while space remains.
// TESTING
//  1. Reset, then a_valid with addr=5, data=0xDEADBEEF, single cycle.
//     -> 2 edges later regwrite=1, cp=0x00000020, data=0xDEADBEEF for one cycle.
//     busy[5]=1 from edge 1 until regwrite drops.
//  2. A(addr 3, 0x11) and M(addr 3, 0x22) valid in the same cycle, FIFO empty.
//     -> both accepted; consecutive cycles show cp=0x8 with data 0x11 then 0x22.
//  3. hold=1; push 4 writes (addrs 1..4) -> full=1, a_ready=0, count=4.
//     Then M valid with A valid -> m_ready=0. Release hold -> 4 consecutive writes in order.
//  4. count=DEPTH-1, A and M both valid -> a_ready=1, m_ready=0.
//     Only A is accepted; M is accepted on the next edge if a pop occurred.
//  5. Request to addr 0 with DISCARD_R0=1 -> handshake completes.
//     count stays 0, regwrite never asserts, busy stays 0.
//  6. rst_n pulled low asynchronously with 3 entries queued and regwrite=1.
//     -> immediate regwrite=0, cp=0, busy=0, count=0. No writes after rst_n rises.

Source files
------------

// File: rtl/wb_write_ctrl.sv
// Write-back controller: merges ALU and load write requests into an in-order FIFO
// and retires at most one register-bank write per cycle, exporting a pending-write scoreboard.
module wb_write_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned AW         = $clog2(NREG),
    parameter int unsigned DEPTH      = 4,
    parameter bit          DISCARD_R0 = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [AW-1:0]              a_addr,
    input  logic [WIDTH-1:0]           a_data,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [AW-1:0]              m_addr,
    input  logic [WIDTH-1:0]           m_data,
    input  logic                       hold,
    output logic                       regwrite,
    output logic [NREG-1:0]            cp,
    output logic [WIDTH-1:0]           data,
    output logic [NREG-1:0]            busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_entry_t;

    wr_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   m_slot;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   free_c;
    logic            a_drop;
    logic            m_drop;
    logic            a_push;
    logic            m_push;
    logic            pop;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Space is judged on pre-pop occupancy so ready never depends on hold.
    assign free_c  = CW'(DEPTH) - count_q;
    assign a_ready = (free_c >= CW'(1));
    assign m_ready = (free_c >= (CW'(1) + CW'(a_valid)));

    assign a_drop = DISCARD_R0 && (a_addr == '0);
    assign m_drop = DISCARD_R0 && (m_addr == '0);
    assign a_push = a_valid & a_ready & ~a_drop;
    assign m_push = m_valid & m_ready & ~m_drop;
    assign pop    = (count_q != '0) & ~hold;

    // A is older than M when both enqueue on the same edge.
    assign m_slot = wr_ptr + PW'(a_push);

    always_ff @(posedge clk) begin
        if (a_push) begin
            mem[wr_ptr] <= '{addr: a_addr, data: a_data};
        end
        if (m_push) begin
            mem[m_slot] <= '{addr: m_addr, data: m_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(a_push) + PW'(m_push);
            rd_ptr  <= rd_ptr + PW'(pop);
            count_q <= count_q + CW'(a_push) + CW'(m_push) - CW'(pop);
        end
    end

    // Bank-facing registers; data holds its last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite <= 1'b0;
            cp       <= '0;
            data     <= '0;
        end else if (pop) begin
            regwrite <= 1'b1;
            cp       <= NREG'(1) << mem[rd_ptr].addr;
            data     <= mem[rd_ptr].data;
        end else begin
            regwrite <= 1'b0;
            cp       <= '0;
        end
    end

    // Pending-write scoreboard: every live FIFO entry plus the write on the bank port.
    always_comb begin
        logic [PW-1:0] offset;
        busy   = regwrite ? cp : '0;
        offset = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset = PW'(i) - rd_ptr;
            if (CW'(offset) < count_q) begin
                busy[mem[i].addr] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_ctrl.sv
// Bench for wb_write_ctrl: accepted writes are queued in a scoreboard and matched
// against every bank write the controller presents.
module tb_wb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, m_valid, hold;
    logic        a_ready, m_ready;
    logic [4:0]  a_addr, m_addr;
    logic [31:0] a_data, m_data;
    logic        regwrite;
    logic [31:0] cp, data, busy;
    logic [2:0]  count;
    logic        empty, full;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sbq[$];
    int  vectors = 0;
    int  miscompares = 0;

    wb_write_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .hold(hold), .regwrite(regwrite), .cp(cp), .data(data), .busy(busy),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Every bank write must match the oldest outstanding accepted request.
    always @(negedge clk) begin
        if (rst_n && regwrite) begin
            wr_t e;
            logic [31:0] ecp;
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL sb_spurious: regwrite with cp=%h data=%h, none expected", cp, data);
            end else begin
                e = sbq.pop_front();
                ecp = 32'd1 << e.addr;
                if (cp !== ecp || data !== e.data) begin
                    miscompares++;
                    $display("FAIL sb_write: got cp=%h data=%h want cp=%h data=%h", cp, data, ecp, e.data);
                end
            end
        end
    end

    task automatic set_in(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic mv, input logic [4:0] ma, input logic [31:0] md,
                          input logic h);
        a_valid = av; a_addr = aa; a_data = ad;
        m_valid = mv; m_addr = ma; m_data = md;
        hold = h;
        #1;
    endtask

    // Records handshakes into the scoreboard, then advances to just after the next edge.
    task automatic step();
        wr_t e;
        if (a_valid && a_ready && a_addr != 5'd0) begin
            e.addr = a_addr; e.data = a_data; sbq.push_back(e);
        end
        if (m_valid && m_ready && m_addr != 5'd0) begin
            e.addr = m_addr; e.data = m_data; sbq.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, h);
            step();
        end
    endtask

    task automatic drain_check(input string name);
        idle(8, 1'b0);
        vectors++;
        if (sbq.size() != 0 || count !== 3'd0 || busy !== 32'd0) begin
            miscompares++;
            $display("FAIL %s_drain: pending=%0d count=%0d busy=%h want 0/0/0", name, sbq.size(), count, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        #11;
        vectors++;
        if (regwrite !== 1'b0 || cp !== 32'd0 || data !== 32'd0 || busy !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: rw=%b cp=%h data=%h busy=%h want all 0", regwrite, cp, data, busy);
        end
        vectors++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_status: count=%0d empty=%b full=%b a_ready=%b want 0/1/0/1", count, empty, full, a_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        vectors++;
        if (regwrite !== 1'b0 || busy !== 32'h20 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL single_edge1: rw=%b busy=%h count=%0d want 0/00000020/1", regwrite, busy, count);
        end
        idle(1, 1'b0);
        vectors++;
        if (regwrite !== 1'b1 || cp !== 32'h20 || data !== 32'hDEADBEEF || busy !== 32'h20) begin
            miscompares++;
            $display("FAIL single_edge2: rw=%b cp=%h data=%h busy=%h want 1/20/deadbeef/20", regwrite, cp, data, busy);
        end
        idle(1, 1'b0);
        vectors++;
        if (regwrite !== 1'b0 || busy !== 32'd0 || data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_edge3: rw=%b busy=%h data=%h want 0/0/deadbeef", regwrite, busy, data);
        end
        drain_check("single");
    endtask

    task automatic test_dual_same_addr();
        set_in(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0);
        vectors++;
        if (a_ready !== 1'b1 || m_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL dual_ready: a_ready=%b m_ready=%b want 1/1", a_ready, m_ready);
        end
        step();
        vectors++;
        if (count !== 3'd2 || busy !== 32'h8) begin
            miscompares++;
            $display("FAIL dual_count: count=%0d busy=%h want 2/8", count, busy);
        end
        idle(1, 1'b0);
        vectors++;
        if (regwrite !== 1'b1 || cp !== 32'h8 || data !== 32'h11) begin
            miscompares++;
            $display("FAIL dual_first: rw=%b cp=%h data=%h want 1/8/11", regwrite, cp, data);
        end
        idle(1, 1'b0);
        vectors++;
        if (regwrite !== 1'b1 || cp !== 32'h8 || data !== 32'h22) begin
            miscompares++;
            $display("FAIL dual_second: rw=%b cp=%h data=%h want 1/8/22", regwrite, cp, data);
        end
        drain_check("dual");
    endtask

    task automatic test_hold_full();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b1);
            step();
        end
        set_in(1'b1, 5'd9, 32'h999, 1'b1, 5'd10, 32'hAAA, 1'b1);
        vectors++;
        if (count !== 3'd4 || full !== 1'b1 || a_ready !== 1'b0 || m_ready !== 1'b0 || busy !== 32'h1E) begin
            miscompares++;
            $display("FAIL full_status: count=%0d full=%b a_rdy=%b m_rdy=%b busy=%h want 4/1/0/0/1e",
                     count, full, a_ready, m_ready, busy);
        end
        step();
        vectors++;
        if (count !== 3'd4 || regwrite !== 1'b0) begin
            miscompares++;
            $display("FAIL full_frozen: count=%0d rw=%b want 4/0", count, regwrite);
        end
        for (int i = 1; i <= 4; i++) begin
            idle(1, 1'b0);
            vectors++;
            if (regwrite !== 1'b1 || cp !== (32'd1 << i)) begin
                miscompares++;
                $display("FAIL full_release_%0d: rw=%b cp=%h want 1/%h", i, regwrite, cp, 32'd1 << i);
            end
        end
        drain_check("full");
    endtask

    task automatic test_almost_full();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(6 + i), 32'h600 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b1);
            step();
        end
        set_in(1'b1, 5'd9, 32'h909, 1'b1, 5'd10, 32'hA0A, 1'b1);
        vectors++;
        if (count !== 3'd3 || a_ready !== 1'b1 || m_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL afull_ready: count=%0d a_rdy=%b m_rdy=%b want 3/1/0", count, a_ready, m_ready);
        end
        step();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0A, 1'b0);
        vectors++;
        if (count !== 3'd4 || m_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL afull_nobypass: count=%0d m_rdy=%b want 4/0", count, m_ready);
        end
        step();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0A, 1'b0);
        vectors++;
        if (count !== 3'd3 || m_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL afull_m_accept: count=%0d m_rdy=%b want 3/1", count, m_ready);
        end
        step();
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL afull_push_pop: count=%0d want 3", count);
        end
        drain_check("afull");
    endtask

    task automatic test_discard_r0();
        set_in(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b0);
        vectors++;
        if (a_ready !== 1'b1 || m_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL r0_ready: a_ready=%b m_ready=%b want 1/1", a_ready, m_ready);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (count !== 3'd0 || busy !== 32'd0 || regwrite !== 1'b0) begin
                miscompares++;
                $display("FAIL r0_cycle%0d: count=%0d busy=%h rw=%b want 0/0/0", i, count, busy, regwrite);
            end
            idle(1, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'(20 + i), 32'hC00 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b1);
            step();
        end
        idle(1, 1'b0);
        vectors++;
        if (regwrite !== 1'b1 || count !== 3'd3) begin
            miscompares++;
            $display("FAIL areset_pre: rw=%b count=%0d want 1/3", regwrite, count);
        end
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        vectors++;
        if (regwrite !== 1'b0 || cp !== 32'd0 || busy !== 32'd0 || count !== 3'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_now: rw=%b cp=%h busy=%h count=%0d empty=%b want 0/0/0/0/1",
                     regwrite, cp, busy, count, empty);
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (regwrite !== 1'b0 || count !== 3'd0) begin
                miscompares++;
                $display("FAIL areset_after%0d: rw=%b count=%0d want 0/0", i, regwrite, count);
            end
            idle(1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   1'($urandom_range(0, 3) == 0));
            step();
        end
        drain_check("b2b");
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_same_addr();
        test_hold_full();
        test_almost_full();
        test_discard_r0();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
